// File: rtl/stage_memory_lsu.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// stage_memory_lsu
//   Memory-stage load/store unit sitting between the EX/MEM and MEM/WB
//   registers. Takes one memory op at a time from the pipeline, checks its
//   alignment, steers byte lanes onto a valid/ready memory bus, waits for the
//   read response (bounded by a timeout) and returns extended load data.
//   The pipeline is held with stall_out while an op is in flight.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   op_valid/op_write    memory op present / 1=store 0=load
//   op_size              0=byte 1=half 2=word 3=dword (64-bit bus only)
//   op_unsigned          zero-extend (1) or sign-extend (0) load data
//   op_addr/op_wdata     byte address / right-justified store data
//   flush                nullify the current op
//   stall_out            hold the pipeline
//   result_valid         one-cycle completion pulse
//   result_data          extended load data, 0 for stores and errors
//   address_error        misaligned address or illegal size (combinational)
//   bus_error            timeout, coincident with result_valid
//   mem_req/mem_we       bus request / write
//   mem_addr/mem_be      bus-aligned address / byte enables
//   mem_wdata            store data replicated across all lanes
//   mem_ready            bus accepts when mem_req && mem_ready
//   mem_rvalid/mem_rdata read response
// ---------------------------------------------------------------------------
module stage_memory_lsu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    input  logic                op_write,
    input  logic [1:0]          op_size,
    input  logic                op_unsigned,
    input  logic [ADDR_W-1:0]   op_addr,
    input  logic [DATA_W-1:0]   op_wdata,
    input  logic                flush,
    output logic                stall_out,
    output logic                result_valid,
    output logic [DATA_W-1:0]   result_data,
    output logic                address_error,
    output logic                bus_error,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BYTES = DATA_W / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [LB-1:0] size_mask(input logic [1:0] size);
        return LB'((1 << size) - 1);
    endfunction

    // A doubleword only exists on a 64-bit bus.
    function automatic logic illegal_size(input logic [1:0] size);
        return (size == 2'd3) && (DATA_W < 64);
    endfunction

    function automatic logic [BYTES-1:0] lane_mask(input logic [1:0] size,
                                                   input logic [LB-1:0] lane);
        logic [BYTES-1:0] base;
        case (size)
            2'd0:    base = BYTES'(1);
            2'd1:    base = BYTES'(3);
            2'd2:    base = BYTES'(15);
            default: base = '1;
        endcase
        return base << lane;
    endfunction

    // Repeat the low (8<<size) bits of the store data over every lane so the
    // enabled bytes always carry the right value regardless of the lane.
    function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] wd,
                                                    input logic [1:0] size);
        logic [DATA_W-1:0] r;
        int                nb;
        r  = '0;
        nb = 1 << size;
        for (int k = 0; k < BYTES; k++) begin
            r[8*k +: 8] = wd[8*(k % nb) +: 8];
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] raw,
                                                      input logic [LB-1:0] lane,
                                                      input logic [1:0] size,
                                                      input logic uns);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] res;
        sh = raw >> {lane, 3'b000};
        case (size)
            2'd0:    res = uns ? DATA_W'(sh[7:0])  : DATA_W'($signed(sh[7:0]));
            2'd1:    res = uns ? DATA_W'(sh[15:0]) : DATA_W'($signed(sh[15:0]));
            2'd2:    res = uns ? DATA_W'(sh[31:0]) : DATA_W'($signed(sh[31:0]));
            default: res = sh;
        endcase
        return res;
    endfunction

    logic [2:0]        state, state_d;
    logic [CNT_W-1:0]  cnt;
    logic              err_q;
    logic              cap_we;
    logic [1:0]        cap_size;
    logic              cap_uns;
    logic [LB-1:0]     cap_lane;
    logic [ADDR_W-1:0] addr_q;
    logic [BYTES-1:0]  be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic misaligned, take, accept, tmo, to_err, done_load;

    assign misaligned = illegal_size(op_size) ||
                        ((op_addr[LB-1:0] & size_mask(op_size)) != '0);
    assign take       = (state == S_IDLE) && op_valid && !misaligned && !flush;
    assign accept     = (state == S_REQ) && mem_ready;
    assign tmo        = (cnt >= CNT_W'(TIMEOUT - 1));
    assign done_load  = (state == S_WAIT) && mem_rvalid && !flush;

    // Completion (accept/rvalid) wins over a timeout in the same cycle; a
    // flush wins over both. A load accepted in the flush cycle still owes a
    // response, so it goes through DRAIN.
    always_comb begin
        state_d = state;
        to_err  = 1'b0;
        case (state)
            S_IDLE:  if (take) state_d = S_REQ;
            S_REQ: begin
                if (flush)       state_d = (accept && !cap_we) ? S_DRAIN : S_IDLE;
                else if (accept) state_d = cap_we ? S_DONE : S_WAIT;
                else if (tmo) begin
                    state_d = S_DONE;
                    to_err  = 1'b1;
                end
            end
            S_WAIT: begin
                if (flush)           state_d = mem_rvalid ? S_IDLE : S_DRAIN;
                else if (mem_rvalid) state_d = S_DONE;
                else if (tmo) begin
                    state_d = S_DONE;
                    to_err  = 1'b1;
                end
            end
            S_DRAIN: if (mem_rvalid || tmo) state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            err_q    <= 1'b0;
            cap_we   <= 1'b0;
            cap_size <= 2'd0;
            cap_uns  <= 1'b0;
            cap_lane <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_d;

            // DRAIN restarts the count so it gets a full timeout budget.
            if (take || (state_d == S_DRAIN && state != S_DRAIN))
                cnt <= '0;
            else if (state inside {S_REQ, S_WAIT, S_DRAIN})
                cnt <= cnt + CNT_W'(1);

            if (take) begin
                cap_we   <= op_write;
                cap_size <= op_size;
                cap_uns  <= op_unsigned;
                cap_lane <= op_addr[LB-1:0];
                addr_q   <= {op_addr[ADDR_W-1:LB], {LB{1'b0}}};
                be_q     <= lane_mask(op_size, op_addr[LB-1:0]);
                wdata_q  <= replicate(op_wdata, op_size);
            end

            // result_data only changes on entry to DONE and holds otherwise.
            if (state_d == S_DONE) begin
                err_q   <= to_err;
                rdata_q <= done_load ? extend_load(mem_rdata, cap_lane, cap_size, cap_uns)
                                     : '0;
            end
        end
    end

    assign address_error = (state == S_IDLE) && op_valid && misaligned && !flush;
    assign stall_out     = take || (state inside {S_REQ, S_WAIT, S_DRAIN});
    assign result_valid  = (state == S_DONE) && !flush;
    assign bus_error     = result_valid && err_q;
    assign result_data   = rdata_q;
    assign mem_req       = (state == S_REQ);
    assign mem_we        = cap_we;
    assign mem_addr      = addr_q;
    assign mem_be        = be_q;
    assign mem_wdata     = wdata_q;

endmodule

// File: tb/tb_stage_memory_lsu.sv
`timescale 1ns/1ps
// Bench for stage_memory_lsu: a 32-bit instance (TIMEOUT=8) and a 64-bit
// instance (TIMEOUT=20) share op and bus inputs; op_valid is steered to one
// of them by sel_b and that instance's outputs are observed.
module tb_stage_memory_lsu;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        op_valid, op_write, op_unsigned, flush, sel_b;
    logic [1:0]  op_size;
    logic [31:0] op_addr;
    logic [63:0] op_wdata;
    logic        mem_ready, mem_rvalid;
    logic [63:0] mem_rdata;

    logic        a_opv, a_stall, a_rv, a_aerr, a_berr, a_req, a_we;
    logic [31:0] a_rd, a_addr, a_wd;
    logic [3:0]  a_be;
    logic        b_opv, b_stall, b_rv, b_aerr, b_berr, b_req, b_we;
    logic [63:0] b_rd, b_wd;
    logic [31:0] b_addr;
    logic [7:0]  b_be;

    logic        s_stall, s_rv, s_aerr, s_berr, s_req, s_we;
    logic [63:0] s_rd, s_wd;
    logic [31:0] s_addr;
    logic [7:0]  s_be;

    assign a_opv   = op_valid & ~sel_b;
    assign b_opv   = op_valid & sel_b;
    assign s_stall = sel_b ? b_stall : a_stall;
    assign s_rv    = sel_b ? b_rv    : a_rv;
    assign s_aerr  = sel_b ? b_aerr  : a_aerr;
    assign s_berr  = sel_b ? b_berr  : a_berr;
    assign s_req   = sel_b ? b_req   : a_req;
    assign s_we    = sel_b ? b_we    : a_we;
    assign s_rd    = sel_b ? b_rd    : {32'h0, a_rd};
    assign s_wd    = sel_b ? b_wd    : {32'h0, a_wd};
    assign s_addr  = sel_b ? b_addr  : a_addr;
    assign s_be    = sel_b ? b_be    : {4'h0, a_be};

    stage_memory_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8)) u_a (
        .clk(clk), .reset(reset), .op_valid(a_opv), .op_write(op_write),
        .op_size(op_size), .op_unsigned(op_unsigned), .op_addr(op_addr),
        .op_wdata(op_wdata[31:0]), .flush(flush), .stall_out(a_stall),
        .result_valid(a_rv), .result_data(a_rd), .address_error(a_aerr),
        .bus_error(a_berr), .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr),
        .mem_be(a_be), .mem_wdata(a_wd), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0])
    );

    stage_memory_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(20)) u_b (
        .clk(clk), .reset(reset), .op_valid(b_opv), .op_write(op_write),
        .op_size(op_size), .op_unsigned(op_unsigned), .op_addr(op_addr),
        .op_wdata(op_wdata), .flush(flush), .stall_out(b_stall),
        .result_valid(b_rv), .result_data(b_rd), .address_error(b_aerr),
        .bus_error(b_berr), .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr),
        .mem_be(b_be), .mem_wdata(b_wd), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    // Observations of the most recent run_op call.
    logic        o_aerr, o_stall0, o_req_seen, o_we, o_berr, o_req_after_done;
    logic [7:0]  o_be;
    logic [63:0] o_wd, o_res;
    logic [31:0] o_maddr;
    int          o_nres, o_done_k, o_stall_low;

    // ---------------- reference model ----------------
    function automatic logic [63:0] bus_mask(input int bytes);
        return (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] field_mask(input int bits);
        return (bits >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
    endfunction

    function automatic logic [63:0] m_load(input int bytes, input int sz, input bit un,
                                           input int lane, input logic [63:0] rd);
        int          bits;
        logic [63:0] m, v;
        bits = 8 << sz;
        m    = field_mask(bits);
        v    = ((rd & bus_mask(bytes)) >> (8 * lane)) & m;
        if (!un && (((v >> (bits - 1)) & 64'd1) != 64'd0)) v = v | ~m;
        return v & bus_mask(bytes);
    endfunction

    function automatic logic [7:0] m_be(input int sz, input int lane);
        return 8'(((1 << (1 << sz)) - 1) << lane);
    endfunction

    function automatic logic [63:0] m_wd(input int bytes, input int sz, input logic [63:0] wd);
        int          bits;
        logic [63:0] w, out;
        bits = 8 << sz;
        w    = wd & field_mask(bits);
        out  = 64'd0;
        for (int i = 0; i < bytes / (1 << sz); i++) out = out | (w << (bits * i));
        return out;
    endfunction

    // ---------------- transaction driver (observes only) ----------------
    // rdy_dly: REQ cycles before mem_ready; rv_dly: cycles from accept to
    // rvalid (-1 = never); flush_at: cycle index of a one-cycle flush (-1 none).
    task automatic run_op(input bit b64, input logic wr, input logic [1:0] sz,
                          input logic un, input logic [31:0] ad, input logic [63:0] wd,
                          input int rdy_dly, input int rv_dly, input logic [63:0] rd,
                          input int flush_at, input int ncyc);
        int req_cnt, acc_k;
        bit acc;
        sel_b = b64;
        o_aerr = 0; o_stall0 = 0; o_req_seen = 0; o_we = 0; o_berr = 0;
        o_req_after_done = 0; o_be = 0; o_wd = 0; o_res = 0; o_maddr = 0;
        o_nres = 0; o_done_k = -1; o_stall_low = -1;
        req_cnt = 0; acc = 0; acc_k = -1;
        @(posedge clk); #1;
        op_valid = 1; op_write = wr; op_size = sz; op_unsigned = un;
        op_addr = ad; op_wdata = wd; flush = 0; mem_ready = 0; mem_rvalid = 0;
        mem_rdata = rd;
        #1;
        o_aerr = s_aerr; o_stall0 = s_stall;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            op_valid = 0; op_write = 1'($urandom); op_size = 2'($urandom);
            op_addr = $urandom; op_wdata = {$urandom, $urandom};
            mem_ready  = s_req && (req_cnt >= rdy_dly);
            mem_rvalid = acc && (rv_dly >= 0) && (k == acc_k + rv_dly);
            flush      = (k == flush_at);
            #1;
            if (s_req) begin
                o_req_seen = 1;
                if (o_done_k >= 0) o_req_after_done = 1;
                if (mem_ready && !acc) begin
                    acc = 1; acc_k = k;
                    o_be = s_be; o_wd = s_wd; o_maddr = s_addr; o_we = s_we;
                end
                req_cnt++;
            end
            if (s_rv) begin
                o_nres++;
                if (o_done_k < 0) begin
                    o_done_k = k; o_res = s_rd; o_berr = s_berr;
                end
            end
            if (!s_stall && o_stall_low < 0) o_stall_low = k;
        end
        mem_ready = 0; mem_rvalid = 0; flush = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({a_stall, a_rv, a_rd, a_aerr, a_berr, a_req, a_we, a_addr, a_be, a_wd} !== '0) begin
            bad++; $display("FAIL reset_a got=%h want=0", {a_stall, a_rv, a_rd, a_aerr, a_berr, a_req, a_we, a_addr, a_be, a_wd}); end
        total++; if ({b_stall, b_rv, b_rd, b_aerr, b_berr, b_req, b_we, b_addr, b_be, b_wd} !== '0) begin
            bad++; $display("FAIL reset_b got=%h want=0", {b_stall, b_rv, b_rd, b_aerr, b_berr, b_req, b_we, b_addr, b_be, b_wd}); end
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({a_stall, a_rv, a_req, b_stall, b_rv, b_req} !== 6'b0) begin
            bad++; $display("FAIL post_reset_idle got=%b want=000000", {a_stall, a_rv, a_req, b_stall, b_rv, b_req}); end
    endtask

    task automatic test_load_ext;
        run_op(0, 0, 2'd0, 0, 32'h1003, 64'h0, 0, 1, 64'h80123456, -1, 8);
        total++; if (o_be !== 8'h08) begin bad++; $display("FAIL lb_be got=%h want=08", o_be); end
        total++; if (o_res !== 64'hFFFF_FF80) begin bad++; $display("FAIL lb_signed got=%h want=ffffff80", o_res); end
        total++; if (o_maddr !== 32'h1000) begin bad++; $display("FAIL lb_addr got=%h want=00001000", o_maddr); end
        total++; if (o_done_k !== 3 || o_nres !== 1) begin bad++; $display("FAIL lb_latency got=%0d/%0d want=3/1", o_done_k, o_nres); end
        run_op(0, 0, 2'd0, 1, 32'h1003, 64'h0, 0, 1, 64'h80123456, -1, 8);
        total++; if (o_res !== 64'h80) begin bad++; $display("FAIL lbu_unsigned got=%h want=80", o_res); end
        run_op(0, 0, 2'd1, 0, 32'h1002, 64'h0, 1, 2, 64'h8001_7F00, -1, 10);
        total++; if (o_res !== m_load(4, 1, 0, 2, 64'h8001_7F00)) begin
            bad++; $display("FAIL lh_signed got=%h want=%h", o_res, m_load(4, 1, 0, 2, 64'h8001_7F00)); end
    endtask

    task automatic test_store_stall;
        run_op(0, 1, 2'd1, 0, 32'h2002, 64'hABCD_1234, 3, -1, 64'h0, -1, 10);
        total++; if (o_be !== 8'h0C) begin bad++; $display("FAIL sh_be got=%h want=0c", o_be); end
        total++; if (o_wd !== 64'h1234_1234) begin bad++; $display("FAIL sh_wdata got=%h want=12341234", o_wd); end
        total++; if (o_we !== 1'b1) begin bad++; $display("FAIL sh_we got=%b want=1", o_we); end
        total++; if (o_done_k !== 5 || o_stall_low !== 5) begin
            bad++; $display("FAIL sh_stall got=done%0d/stalllow%0d want=5/5", o_done_k, o_stall_low); end
        total++; if (o_nres !== 1 || o_res !== 64'h0 || o_berr !== 1'b0) begin
            bad++; $display("FAIL sh_result got=n%0d/%h/%b want=1/0/0", o_nres, o_res, o_berr); end
    endtask

    task automatic test_misaligned;
        run_op(0, 0, 2'd2, 0, 32'h3001, 64'h0, 0, 1, 64'h0, -1, 6);
        total++; if (o_aerr !== 1'b1 || o_stall0 !== 1'b0) begin
            bad++; $display("FAIL lw_misaligned got=aerr%b/stall%b want=1/0", o_aerr, o_stall0); end
        total++; if (o_req_seen !== 1'b0 || o_nres !== 0) begin
            bad++; $display("FAIL lw_misaligned_bus got=req%b/n%0d want=0/0", o_req_seen, o_nres); end
        run_op(0, 0, 2'd3, 0, 32'h3000, 64'h0, 0, 1, 64'h0, -1, 6);
        total++; if (o_aerr !== 1'b1 || o_req_seen !== 1'b0) begin
            bad++; $display("FAIL ld_on_32 got=aerr%b/req%b want=1/0", o_aerr, o_req_seen); end
        // flush suppresses the combinational error
        sel_b = 0;
        @(posedge clk); #1;
        op_valid = 1; op_size = 2'd2; op_addr = 32'h3001; flush = 1;
        #1;
        total++; if (a_aerr !== 1'b0 || a_stall !== 1'b0) begin
            bad++; $display("FAIL aerr_flush got=%b%b want=00", a_aerr, a_stall); end
        flush = 0;
        #1;
        total++; if (a_aerr !== 1'b1) begin bad++; $display("FAIL aerr_noflush got=%b want=1", a_aerr); end
        op_valid = 0;
    endtask

    task automatic test_timeout;
        run_op(0, 0, 2'd2, 0, 32'h100, 64'h0, 0, 10, 64'h1234_5678, -1, 14);
        total++; if (o_done_k !== 9 || o_berr !== 1'b1) begin
            bad++; $display("FAIL tmo_load got=done%0d/berr%b want=9/1", o_done_k, o_berr); end
        total++; if (o_res !== 64'h0 || o_nres !== 1) begin
            bad++; $display("FAIL tmo_load_data got=%h/n%0d want=0/1", o_res, o_nres); end
        run_op(0, 1, 2'd2, 0, 32'h104, 64'h5, 100, -1, 64'h0, -1, 12);
        total++; if (o_done_k !== 9 || o_berr !== 1'b1 || o_req_after_done !== 1'b0) begin
            bad++; $display("FAIL tmo_req got=done%0d/berr%b/req%b want=9/1/0", o_done_k, o_berr, o_req_after_done); end
    endtask

    task automatic test_flush;
        run_op(0, 0, 2'd2, 0, 32'h40, 64'h0, 0, 3, 64'hCAFE_F00D, 2, 10);
        total++; if (o_nres !== 0) begin bad++; $display("FAIL flush_result got=n%0d want=0", o_nres); end
        total++; if (o_stall_low !== 5) begin bad++; $display("FAIL flush_drain got=%0d want=5", o_stall_low); end
        run_op(0, 0, 2'd1, 1, 32'h42, 64'h0, 0, 1, 64'hBEEF_0000, -1, 8);
        total++; if (o_res !== 64'hBEEF || o_done_k !== 3) begin
            bad++; $display("FAIL after_flush got=%h/%0d want=beef/3", o_res, o_done_k); end
    endtask

    task automatic test_dword64;
        logic [63:0] rd;
        rd = {$urandom, $urandom};
        run_op(1, 0, 2'd3, 0, 32'h8, 64'h0, 1, 1, rd, -1, 8);
        total++; if (o_be !== 8'hFF || o_maddr !== 32'h8) begin
            bad++; $display("FAIL ld64_be got=%h/%h want=ff/00000008", o_be, o_maddr); end
        total++; if (o_res !== rd || o_aerr !== 1'b0) begin
            bad++; $display("FAIL ld64_data got=%h want=%h", o_res, rd); end
    endtask

    task automatic test_reset_mid;
        int nrv;
        sel_b = 1;
        @(posedge clk); #1;
        op_valid = 1; op_write = 0; op_size = 2'd2; op_addr = 32'h10; mem_ready = 0;
        @(posedge clk); #1;
        op_valid = 0;
        total++; if (b_req !== 1'b1) begin bad++; $display("FAIL mid_req got=%b want=1", b_req); end
        #1 reset = 0;
        #1;
        total++; if (b_req !== 1'b0 || b_stall !== 1'b0) begin
            bad++; $display("FAIL mid_async got=req%b/stall%b want=0/0", b_req, b_stall); end
        @(posedge clk); #1;
        reset = 1;
        nrv = 0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = (k < 2);
            mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
            @(posedge clk); #1;
            if (b_rv || b_req || b_stall) nrv++;
        end
        mem_rvalid = 0;
        total++; if (nrv !== 0) begin bad++; $display("FAIL mid_ignore got=%0d want=0", nrv); end
        run_op(1, 0, 2'd1, 1, 32'h6, 64'h0, 0, 1, 64'hBEEF << 48, -1, 8);
        total++; if (o_res !== 64'hBEEF || o_be !== 8'hC0) begin
            bad++; $display("FAIL lhu64 got=%h/%h want=beef/c0", o_res, o_be); end
    endtask

    task automatic test_back_to_back;
        logic [5:0]  rv_m, req_m, st_m;
        logic [31:0] addr4;
        sel_b = 0; rv_m = 0; req_m = 0; st_m = 0; addr4 = 0;
        @(posedge clk); #1;
        op_valid = 1; op_write = 1; op_size = 2'd2; op_addr = 32'h500;
        op_wdata = 64'h1; mem_ready = 1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 3) op_addr = 32'h600;
            if (k == 4) op_valid = 0;
            #1;
            rv_m[k-1] = a_rv; req_m[k-1] = a_req; st_m[k-1] = a_stall;
            if (k == 4) addr4 = a_addr;
        end
        mem_ready = 0;
        total++; if (rv_m !== 6'b010010) begin bad++; $display("FAIL b2b_rv got=%b want=010010", rv_m); end
        total++; if (req_m !== 6'b001001) begin bad++; $display("FAIL b2b_req got=%b want=001001", req_m); end
        total++; if (st_m !== 6'b001101) begin bad++; $display("FAIL b2b_stall got=%b want=001101", st_m); end
        total++; if (addr4 !== 32'h600) begin bad++; $display("FAIL b2b_addr got=%h want=00000600", addr4); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 40; it++) begin
            bit          b64, wr, un, mis;
            int          sz, bytes, rdy, rv, lane, exp_done;
            logic [31:0] ad;
            logic [63:0] wd, rd, exp_res;
            b64   = 1'($urandom);
            bytes = b64 ? 8 : 4;
            sz    = $urandom_range(3, 0);
            ad    = $urandom;
            if ($urandom_range(1, 0) == 1) ad = ad & ~32'((1 << sz) - 1);
            wr = 1'($urandom); un = 1'($urandom);
            rdy = $urandom_range(3, 0); rv = $urandom_range(3, 1);
            wd = {$urandom, $urandom}; rd = {$urandom, $urandom};
            mis  = (sz == 3 && !b64) || ((ad % (1 << sz)) != 0);
            lane = int'(ad % bytes);
            run_op(b64, wr, 2'(sz), un, ad, wd, rdy, rv, rd, -1, 12);
            if (mis) begin
                total++; if (o_aerr !== 1'b1 || o_req_seen !== 1'b0 || o_nres !== 0) begin
                    bad++; $display("FAIL rnd_mis it=%0d got=aerr%b/req%b/n%0d want=1/0/0", it, o_aerr, o_req_seen, o_nres); end
            end else begin
                exp_done = 1 + rdy + (wr ? 1 : rv + 1);
                exp_res  = wr ? 64'h0 : m_load(bytes, sz, un, lane, rd);
                total++; if (o_aerr !== 1'b0 || o_nres !== 1 || o_berr !== 1'b0) begin
                    bad++; $display("FAIL rnd_status it=%0d got=aerr%b/n%0d/berr%b want=0/1/0", it, o_aerr, o_nres, o_berr); end
                total++; if (o_done_k !== exp_done || o_stall_low !== exp_done) begin
                    bad++; $display("FAIL rnd_latency it=%0d got=%0d/%0d want=%0d", it, o_done_k, o_stall_low, exp_done); end
                total++; if (o_be !== m_be(sz, lane) || o_maddr !== (ad & ~32'(bytes - 1)) || o_we !== wr) begin
                    bad++; $display("FAIL rnd_bus it=%0d got=%h/%h/%b want=%h/%h/%b", it, o_be, o_maddr, o_we, m_be(sz, lane), ad & ~32'(bytes - 1), wr); end
                total++; if (o_wd !== m_wd(bytes, sz, wd)) begin
                    bad++; $display("FAIL rnd_wdata it=%0d got=%h want=%h", it, o_wd, m_wd(bytes, sz, wd)); end
                total++; if (o_res !== exp_res) begin
                    bad++; $display("FAIL rnd_result it=%0d got=%h want=%h", it, o_res, exp_res); end
            end
        end
    endtask

    initial begin
        op_valid = 0; op_write = 0; op_unsigned = 0; flush = 0; sel_b = 0;
        op_size = 0; op_addr = 0; op_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        reset = 0;
        test_reset;
        test_load_ext;
        test_store_stall;
        test_misaligned;
        test_timeout;
        test_flush;
        test_dword64;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
